// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter fed by a synchronous byte FIFO.
// A byte written into an empty FIFO while idle starts its start bit on the
// following edge; frames run back to back while the FIFO has data.
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 139,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_write_data,
  input  logic       i_write_enable,
  output logic       o_tx,
  output logic       o_full,
  output logic       o_empty,
  output logic       o_busy,
  output logic       o_overflow
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            r_state, w_state_next;
  logic [BAUD_W-1:0] r_baud, w_baud_next;
  logic [2:0]        r_bit, w_bit_next;
  logic [7:0]        r_shift, w_shift_next;
  logic [7:0]        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_count, w_count_next;
  logic              r_tx, r_full, r_empty, r_busy, r_overflow;
  logic              w_push, w_pop, w_tx_next, w_bit_done;

  // A write is accepted only when the FIFO was not full after the last edge,
  // so a pop on the same edge never rescues a write into a full FIFO.
  assign w_push     = i_write_enable && !r_full;
  assign w_bit_done = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));

  // Next-state, datapath and next-output logic for the transmitter.
  always_comb begin
    w_state_next = r_state;
    w_baud_next  = r_baud;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_pop        = 1'b0;
    w_count_next = r_count;
    w_tx_next    = 1'b1;

    unique case (r_state)
      IDLE: begin
        if (!r_empty) begin
          w_state_next = START;
          w_pop        = 1'b1;
          w_shift_next = r_mem[r_rd_ptr];
          w_baud_next  = '0;
          w_bit_next   = '0;
        end
      end
      START: begin
        if (w_bit_done) begin
          w_state_next = DATA;
          w_baud_next  = '0;
        end else begin
          w_baud_next = r_baud + BAUD_W'(1);
        end
      end
      DATA: begin
        if (w_bit_done) begin
          w_baud_next  = '0;
          w_shift_next = r_shift >> 1;
          if (r_bit == 3'd7) begin
            w_state_next = STOP;
          end else begin
            w_bit_next = r_bit + 3'd1;
          end
        end else begin
          w_baud_next = r_baud + BAUD_W'(1);
        end
      end
      STOP: begin
        if (w_bit_done) begin
          w_baud_next = '0;
          if (!r_empty) begin
            w_state_next = START;
            w_pop        = 1'b1;
            w_shift_next = r_mem[r_rd_ptr];
            w_bit_next   = '0;
          end else begin
            w_state_next = IDLE;
          end
        end else begin
          w_baud_next = r_baud + BAUD_W'(1);
        end
      end
      default: w_state_next = IDLE;
    endcase

    unique case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CNT_W'(1);
      2'b01:   w_count_next = r_count - CNT_W'(1);
      default: w_count_next = r_count;
    endcase

    unique case (w_state_next)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = w_shift_next[0];
      default: w_tx_next = 1'b1;
    endcase
  end

  // State, pointers, occupancy and registered status outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_baud     <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_tx       <= 1'b1;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_baud  <= w_baud_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
      r_count <= w_count_next;
      r_tx    <= w_tx_next;
      r_full  <= (w_count_next == CNT_W'(FIFO_DEPTH));
      r_empty <= (w_count_next == '0);
      r_busy  <= (w_state_next != IDLE) || (w_count_next != '0);
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (i_write_enable && r_full) r_overflow <= 1'b1;
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge i_clk) begin
    if (!i_reset && w_push) r_mem[r_wr_ptr] <= i_write_data;
  end

  assign o_tx       = r_tx;
  assign o_full     = r_full;
  assign o_empty    = r_empty;
  assign o_busy     = r_busy;
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three instances (139/16, 4/16, 2/4), a serial
// decoder feeding a scoreboard, a frame table and corner-case sequences.
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] wdata;
  logic       we0, we1, we2;
  logic       tx0, full0, empty0, busy0, ovf0;
  logic       tx1, full1, empty1, busy1, ovf1;
  logic       tx2, full2, empty2, busy2, ovf2;

  uart_tx_fifo #(.CLKS_PER_BIT(139), .FIFO_DEPTH(16)) u_dut0 (
    .i_clk(clk), .i_reset(rst), .i_write_data(wdata), .i_write_enable(we0),
    .o_tx(tx0), .o_full(full0), .o_empty(empty0), .o_busy(busy0), .o_overflow(ovf0));
  uart_tx_fifo #(.CLKS_PER_BIT(4), .FIFO_DEPTH(16)) u_dut1 (
    .i_clk(clk), .i_reset(rst), .i_write_data(wdata), .i_write_enable(we1),
    .o_tx(tx1), .o_full(full1), .o_empty(empty1), .o_busy(busy1), .o_overflow(ovf1));
  uart_tx_fifo #(.CLKS_PER_BIT(2), .FIFO_DEPTH(4)) u_dut2 (
    .i_clk(clk), .i_reset(rst), .i_write_data(wdata), .i_write_enable(we2),
    .o_tx(tx2), .o_full(full2), .o_empty(empty2), .o_busy(busy2), .o_overflow(ovf2));

  int         n_vec = 0;
  int         n_err = 0;
  int         sel = 0;
  int         n_frames = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // bit i is the i-th bit on the line: start, D0..D7, stop
  } vec_t;
  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic tx_of(input int s);
    case (s)
      0:       return tx0;
      1:       return tx1;
      default: return tx2;
    endcase
  endfunction

  function automatic int cpb_of(input int s);
    case (s)
      0:       return 139;
      1:       return 4;
      default: return 2;
    endcase
  endfunction

  task automatic wait_neg(input int n, inout logic ab);
    repeat (n) begin
      @(negedge clk);
      if (rst) ab = 1'b1;
    end
  endtask

  // Serial decoder for the selected instance; frames hit by reset are discarded.
  initial begin : decoder
    logic [7:0] b;
    logic       ab, st, sb;
    int         c;
    forever begin
      @(negedge clk);
      if (!rst && tx_of(sel) == 1'b0) begin
        c  = cpb_of(sel);
        ab = 1'b0;
        b  = '0;
        wait_neg(c / 2, ab);
        sb = tx_of(sel);
        for (int i = 0; i < 8; i++) begin
          wait_neg(c, ab);
          b[3'(i)] = tx_of(sel);
        end
        wait_neg(c, ab);
        st = tx_of(sel);
        if (!ab) begin
          n_frames++;
          check("start_bit", 32'(sb), 32'd0);
          check("stop_bit", 32'(st), 32'd1);
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_frame: got %02h expected none", b);
          end else begin
            check("rx_byte", 32'(b), 32'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  // Drives one or two bytes on consecutive edges into instance 0 and checks the line every cycle.
  task automatic send_and_watch(input logic [7:0] d0, input logic [7:0] d1,
                                input logic [9:0] f0, input logic [9:0] f1,
                                input int nfr, input string name);
    logic [19:0] fr;
    int          bad;
    fr  = {f1, f0};
    bad = 0;
    wdata = d0;
    we0   = 1'b1;
    exp_q.push_back(d0);
    tick();
    check({name, "_lat0"}, 32'({tx0, empty0, busy0}), 32'b101);
    if (nfr == 2) begin
      wdata = d1;
      exp_q.push_back(d1);
    end else begin
      we0 = 1'b0;
    end
    for (int c = 1; c <= nfr * 1390 + 1; c++) begin
      tick();
      we0 = 1'b0;
      if (c <= nfr * 1390) begin
        if (tx0 !== fr[5'((c - 1) / 139)] || busy0 !== 1'b1) bad++;
      end
    end
    check({name, "_bad_cycles"}, 32'(bad), 32'd0);
    check({name, "_idle"}, 32'({tx0, busy0, empty0}), 32'b101);
  endtask

  task automatic wait_drain(input int limit, input string name);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < limit) begin
      tick();
      w++;
    end
    check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int  f0, bad, w;
    logic saw_full;

    vecs[0] = '{8'hA5, 10'h34A};
    vecs[1] = '{8'h00, 10'h200};
    vecs[2] = '{8'h3C, 10'h278};
    vecs[3] = '{8'h80, 10'h300};
    vecs[4] = '{8'h01, 10'h202};

    rst = 1'b1; we0 = 1'b0; we1 = 1'b0; we2 = 1'b0; wdata = '0; sel = 0;
    tick();
    we0 = 1'b1; wdata = 8'h77;  // write during reset must be ignored
    tick();
    rst = 1'b0; we0 = 1'b0;
    check("reset0", 32'({tx0, empty0, full0, busy0, ovf0}), 32'b11000);
    check("reset1", 32'({tx1, empty1, full1, busy1, ovf1}), 32'b11000);
    check("reset2", 32'({tx2, empty2, full2, busy2, ovf2}), 32'b11000);
    repeat (3) tick();
    check("reset_write_ignored", 32'({tx0, empty0, busy0}), 32'b110);

    // Single frames at 139 clocks per bit, busy falling 1391 edges after the write
    for (int i = 0; i < 5; i++) begin
      send_and_watch(vecs[i].data, 8'h00, vecs[i].frame, 10'h000, 1, "table");
      repeat (5) tick();
    end

    // Back-to-back frames with no idle gap between stop and next start
    send_and_watch(8'hFF, 8'h11, 10'h3FE, 10'h222, 2, "b2b");
    check("sb_empty0", 32'(exp_q.size()), 32'd0);

    // Fill: byte 1 leaves on the second edge, so 17 writes leave 16 held.
    // The frame of byte 1 ends on edge 42; a write there finds the FIFO full
    // and is dropped even though that edge pops byte 2.
    sel = 1;
    for (int i = 0; i < 17; i++) begin
      wdata = 8'(8'h40 + i);
      we1 = 1'b1;
      exp_q.push_back(8'(8'h40 + i));
      tick();
    end
    we1 = 1'b0;
    check("fill_full", 32'({full1, ovf1, empty1}), 32'b100);
    repeat (24) tick();
    check("fill_still_full", 32'({full1, ovf1}), 32'b10);
    wdata = 8'hEE; we1 = 1'b1;
    tick();
    we1 = 1'b0;
    check("drop_on_pop_edge", 32'({full1, ovf1, empty1}), 32'b010);
    wait_drain(16 * 40 + 100, "fill");
    repeat (10) tick();
    check("fill_end", 32'({busy1, empty1, ovf1, tx1}), 32'b0111);

    // Reset during DATA bit 3 of 0x3C with two bytes queued
    rst = 1'b1; tick(); rst = 1'b0;
    check("ovf_cleared_by_reset", 32'(ovf1), 32'd0);
    wdata = 8'h3C; we1 = 1'b1; exp_q.push_back(8'h3C); tick();
    wdata = 8'h5A; exp_q.push_back(8'h5A); tick();
    wdata = 8'h96; exp_q.push_back(8'h96); tick();
    we1 = 1'b0;
    repeat (15) tick();
    check("pre_reset", 32'({busy1, empty1}), 32'b10);
    rst = 1'b1; we1 = 1'b1; wdata = 8'hC3;
    tick();
    rst = 1'b0; we1 = 1'b0;
    exp_q.delete();
    check("mid_frame_reset", 32'({tx1, empty1, busy1, full1}), 32'b1100);
    f0 = n_frames;
    bad = 0;
    repeat (100) begin
      tick();
      if (tx1 !== 1'b1 || busy1 !== 1'b0) bad++;
    end
    check("post_reset_quiet", 32'(bad), 32'd0);
    check("post_reset_frames", 32'(n_frames - f0), 32'd0);

    // Pointer wrap on the 4-deep instance, writing only when not full
    sel = 2;
    saw_full = 1'b0;
    for (int i = 0; i < 10; i++) begin
      w = 0;
      while (full2 && w < 200) begin
        saw_full = 1'b1;
        tick();
        w++;
      end
      if (w >= 200) check("wrap_wait_timeout", 32'(w), 32'd0);
      wdata = 8'(i); we2 = 1'b1;
      exp_q.push_back(8'(i));
      tick();
      we2 = 1'b0;
    end
    wait_drain(600, "wrap");
    repeat (6) tick();
    check("wrap_saw_full", 32'(saw_full), 32'd1);
    check("wrap_end", 32'({ovf2, busy2, empty2}), 32'b001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
